// File: rtl/aludec_pkg.sv
// Shared MIPS opcode, funct and ALU control constants for the ALU decode stage.
// Also holds the HI/LO classification helpers.
package aludec_pkg;

    localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;

    localparam logic [5:0] EXE_ADDI  = 6'b001000;
    localparam logic [5:0] EXE_ADDIU = 6'b001001;
    localparam logic [5:0] EXE_SLTI  = 6'b001010;
    localparam logic [5:0] EXE_SLTIU = 6'b001011;
    localparam logic [5:0] EXE_ANDI  = 6'b001100;
    localparam logic [5:0] EXE_ORI   = 6'b001101;
    localparam logic [5:0] EXE_XORI  = 6'b001110;
    localparam logic [5:0] EXE_LUI   = 6'b001111;
    localparam logic [5:0] EXE_LB    = 6'b100000;
    localparam logic [5:0] EXE_LH    = 6'b100001;
    localparam logic [5:0] EXE_LW    = 6'b100011;
    localparam logic [5:0] EXE_LBU   = 6'b100100;
    localparam logic [5:0] EXE_LHU   = 6'b100101;
    localparam logic [5:0] EXE_SB    = 6'b101000;
    localparam logic [5:0] EXE_SH    = 6'b101001;
    localparam logic [5:0] EXE_SW    = 6'b101011;

    localparam logic [5:0] EXE_SLL   = 6'b000000;
    localparam logic [5:0] EXE_SRL   = 6'b000010;
    localparam logic [5:0] EXE_SRA   = 6'b000011;
    localparam logic [5:0] EXE_SLLV  = 6'b000100;
    localparam logic [5:0] EXE_SRLV  = 6'b000110;
    localparam logic [5:0] EXE_SRAV  = 6'b000111;
    localparam logic [5:0] EXE_MFHI  = 6'b010000;
    localparam logic [5:0] EXE_MTHI  = 6'b010001;
    localparam logic [5:0] EXE_MFLO  = 6'b010010;
    localparam logic [5:0] EXE_MTLO  = 6'b010011;
    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV   = 6'b011010;
    localparam logic [5:0] EXE_DIVU  = 6'b011011;
    localparam logic [5:0] EXE_ADD   = 6'b100000;
    localparam logic [5:0] EXE_ADDU  = 6'b100001;
    localparam logic [5:0] EXE_SUB   = 6'b100010;
    localparam logic [5:0] EXE_SUBU  = 6'b100011;
    localparam logic [5:0] EXE_AND   = 6'b100100;
    localparam logic [5:0] EXE_OR    = 6'b100101;
    localparam logic [5:0] EXE_XOR   = 6'b100110;
    localparam logic [5:0] EXE_NOR   = 6'b100111;
    localparam logic [5:0] EXE_SLT   = 6'b101010;
    localparam logic [5:0] EXE_SLTU  = 6'b101011;

    localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_ANDI_OP  = 8'b01011001;
    localparam logic [7:0] EXE_ORI_OP   = 8'b01011010;
    localparam logic [7:0] EXE_XORI_OP  = 8'b01011011;
    localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SLLV_OP  = 8'b00000100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SRLV_OP  = 8'b00000110;
    localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [7:0] EXE_SRAV_OP  = 8'b00000111;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
    localparam logic [7:0] EXE_SLTI_OP  = 8'b01010111;
    localparam logic [7:0] EXE_SLTIU_OP = 8'b01011000;
    localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
    localparam logic [7:0] EXE_LB_OP    = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP   = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP    = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP   = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP    = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP    = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP    = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP    = 8'b11101011;

    function automatic logic is_muldiv(input logic [31:0] instr);
        return (instr[31:26] == EXE_SPECIAL_INST) &&
               (instr[5:0] inside {EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU});
    endfunction

    function automatic logic is_div(input logic [31:0] instr);
        return (instr[31:26] == EXE_SPECIAL_INST) &&
               (instr[5:0] inside {EXE_DIV, EXE_DIVU});
    endfunction

    function automatic logic is_hilo(input logic [31:0] instr);
        return is_muldiv(instr) ||
               ((instr[31:26] == EXE_SPECIAL_INST) &&
                (instr[5:0] inside {EXE_MFHI, EXE_MTHI, EXE_MFLO, EXE_MTLO}));
    endfunction

endpackage

// File: rtl/aludec_core.sv
// Combinational ALU control decoder: instruction word to ALU op code.
// Unknown opcodes or SPECIAL functs yield EXE_NOP_OP with illegal set.
module aludec_core
    import aludec_pkg::*;
#(
    parameter int ALUOP_W = 8
) (
    input  logic [31:0]        instr,
    output logic [ALUOP_W-1:0] alucontrol,
    output logic               illegal
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [7:0] code;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign alucontrol = ALUOP_W'(code);

    // Map opcode (and funct for SPECIAL) onto the 8-bit ALU op code
    always_comb begin
        code    = EXE_NOP_OP;
        illegal = 1'b0;
        if (instr == 32'h0) begin
            code = EXE_SLL_OP;
        end else begin
            unique case (op)
                EXE_SPECIAL_INST: begin
                    unique case (fn)
                        EXE_AND:   code = EXE_AND_OP;
                        EXE_OR:    code = EXE_OR_OP;
                        EXE_XOR:   code = EXE_XOR_OP;
                        EXE_NOR:   code = EXE_NOR_OP;
                        EXE_SLL:   code = EXE_SLL_OP;
                        EXE_SRL:   code = EXE_SRL_OP;
                        EXE_SRA:   code = EXE_SRA_OP;
                        EXE_SLLV:  code = EXE_SLLV_OP;
                        EXE_SRLV:  code = EXE_SRLV_OP;
                        EXE_SRAV:  code = EXE_SRAV_OP;
                        EXE_MFHI:  code = EXE_MFHI_OP;
                        EXE_MTHI:  code = EXE_MTHI_OP;
                        EXE_MFLO:  code = EXE_MFLO_OP;
                        EXE_MTLO:  code = EXE_MTLO_OP;
                        EXE_MULT:  code = EXE_MULT_OP;
                        EXE_MULTU: code = EXE_MULTU_OP;
                        EXE_DIV:   code = EXE_DIV_OP;
                        EXE_DIVU:  code = EXE_DIVU_OP;
                        EXE_ADD:   code = EXE_ADD_OP;
                        EXE_ADDU:  code = EXE_ADDU_OP;
                        EXE_SUB:   code = EXE_SUB_OP;
                        EXE_SUBU:  code = EXE_SUBU_OP;
                        EXE_SLT:   code = EXE_SLT_OP;
                        EXE_SLTU:  code = EXE_SLTU_OP;
                        default:   illegal = 1'b1;
                    endcase
                end
                EXE_ANDI:  code = EXE_ANDI_OP;
                EXE_ORI:   code = EXE_ORI_OP;
                EXE_XORI:  code = EXE_XORI_OP;
                EXE_LUI:   code = EXE_LUI_OP;
                EXE_ADDI:  code = EXE_ADDI_OP;
                EXE_ADDIU: code = EXE_ADDIU_OP;
                EXE_SLTI:  code = EXE_SLTI_OP;
                EXE_SLTIU: code = EXE_SLTIU_OP;
                EXE_LB:    code = EXE_LB_OP;
                EXE_LBU:   code = EXE_LBU_OP;
                EXE_LH:    code = EXE_LH_OP;
                EXE_LHU:   code = EXE_LHU_OP;
                EXE_LW:    code = EXE_LW_OP;
                EXE_SB:    code = EXE_SB_OP;
                EXE_SH:    code = EXE_SH_OP;
                EXE_SW:    code = EXE_SW_OP;
                default:   illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/aludec_stage.sv
// Registered ALU decode stage with valid/ready handshake, flush and HI/LO busy tracking.
// Optional ALUDEC_PERF_CNT_EN adds a 32-bit hazard stall counter output.
module aludec_stage
    import aludec_pkg::*;
#(
    parameter int ALUOP_W = 8,
    parameter int DIV_LAT = 36,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [ALUOP_W-1:0] out_alucontrol,
    output logic               out_illegal,
    output logic               hilo_busy
`ifdef ALUDEC_PERF_CNT_EN
    ,
    output logic [31:0]        hazard_stall_cnt
`endif
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [ALUOP_W-1:0] dec_op;
    logic               dec_ill;
    logic [CNT_W-1:0]   cnt;
    logic               hazard;
    logic               accept;
    logic               handoff;

    aludec_core #(
        .ALUOP_W(ALUOP_W)
    ) u_core (
        .instr     (in_instr),
        .alucontrol(dec_op),
        .illegal   (dec_ill)
    );

    // A HI/LO reader/writer waits while a mul/div is held or still running
    assign hazard = is_hilo(in_instr) &&
                    ((cnt != '0) || (out_valid && is_muldiv(out_instr)));
    assign in_ready  = (!out_valid || out_ready) && !hazard && !flush;
    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid && out_ready;
    assign hilo_busy = (cnt != '0);

    // Output register: flush kills, accept loads, handoff empties
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid      <= 1'b0;
            out_instr      <= 32'h0;
            out_alucontrol <= ALUOP_W'(EXE_NOP_OP);
            out_illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_instr      <= in_instr;
            out_alucontrol <= dec_op;
            out_illegal    <= dec_ill;
        end else if (handoff) begin
            out_valid <= 1'b0;
        end
    end

    // Busy counter: loaded when a mul/div leaves, survives flush
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (handoff && is_muldiv(out_instr)) begin
            cnt <= is_div(out_instr) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef ALUDEC_PERF_CNT_EN
    // Count cycles a valid instruction is held back by the HI/LO hazard
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hazard_stall_cnt <= 32'h0;
        end else if (in_valid && hazard && !flush) begin
            hazard_stall_cnt <= hazard_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aludec_stage.sv
// Testbench for aludec_stage: directed scenarios plus a randomized run
// against a table-driven reference model.
module tb_aludec_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_alucontrol;
    logic        out_illegal;
    logic        hilo_busy;
`ifdef ALUDEC_PERF_CNT_EN
    logic [31:0] perf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_ADDIU = 32'h24010005;
    localparam logic [31:0] I_ILL   = 32'hFC000000;
    localparam logic [31:0] I_SUBU  = 32'h00851023;
    localparam logic [31:0] I_ADDU  = 32'h00851021;
    localparam logic [31:0] I_DIV   = 32'h0085001A;
    localparam logic [31:0] I_MFLO  = 32'h00001012;

    aludec_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_alucontrol(out_alucontrol),
        .out_illegal   (out_illegal),
        .hilo_busy     (hilo_busy)
`ifdef ALUDEC_PERF_CNT_EN
        ,
        .hazard_stall_cnt(perf)
`endif
    );

    always #5 clk = ~clk;

    // kind: 0 plain, 1 HI/LO move, 2 multiply, 3 divide
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [7:0] code;
        int         kind;
    } ent_t;

    ent_t tbl[$];

    function automatic void add(input logic [5:0] op, input logic [5:0] fn,
                                input logic [7:0] code, input int kind);
        ent_t e;
        e.op = op; e.fn = fn; e.code = code; e.kind = kind;
        tbl.push_back(e);
    endfunction

    function automatic void build_table();
        add(6'h0C, 0, 8'h59, 0); add(6'h0D, 0, 8'h5A, 0);
        add(6'h0E, 0, 8'h5B, 0); add(6'h0F, 0, 8'h5C, 0);
        add(6'h08, 0, 8'h55, 0); add(6'h09, 0, 8'h56, 0);
        add(6'h0A, 0, 8'h57, 0); add(6'h0B, 0, 8'h58, 0);
        add(6'h20, 0, 8'hE0, 0); add(6'h21, 0, 8'hE1, 0);
        add(6'h23, 0, 8'hE3, 0); add(6'h24, 0, 8'hE4, 0);
        add(6'h25, 0, 8'hE5, 0); add(6'h28, 0, 8'hE8, 0);
        add(6'h29, 0, 8'hE9, 0); add(6'h2B, 0, 8'hEB, 0);
        add(0, 6'h24, 8'h24, 0); add(0, 6'h25, 8'h25, 0);
        add(0, 6'h26, 8'h26, 0); add(0, 6'h27, 8'h27, 0);
        add(0, 6'h00, 8'h7C, 0); add(0, 6'h02, 8'h02, 0);
        add(0, 6'h03, 8'h03, 0); add(0, 6'h04, 8'h04, 0);
        add(0, 6'h06, 8'h06, 0); add(0, 6'h07, 8'h07, 0);
        add(0, 6'h10, 8'h10, 1); add(0, 6'h11, 8'h11, 1);
        add(0, 6'h12, 8'h12, 1); add(0, 6'h13, 8'h13, 1);
        add(0, 6'h18, 8'h18, 2); add(0, 6'h19, 8'h19, 2);
        add(0, 6'h1A, 8'h1A, 3); add(0, 6'h1B, 8'h1B, 3);
        add(0, 6'h20, 8'h20, 0); add(0, 6'h21, 8'h21, 0);
        add(0, 6'h22, 8'h22, 0); add(0, 6'h23, 8'h23, 0);
        add(0, 6'h2A, 8'h2A, 0); add(0, 6'h2B, 8'h2B, 0);
    endfunction

    function automatic void ref_decode(input logic [31:0] w, output logic [7:0] code,
                                       output logic ill, output int kind);
        code = 8'h00; ill = 1'b1; kind = 0;
        foreach (tbl[i]) begin
            if (tbl[i].op == w[31:26] && (w[31:26] != 6'd0 || tbl[i].fn == w[5:0])) begin
                code = tbl[i].code; ill = 1'b0; kind = tbl[i].kind;
            end
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        int   r;
        ent_t e;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom;
        if (r == 1) return 32'h0;
        if (r <= 4) e = tbl[$urandom_range(26, 33)];
        else e = tbl[$urandom_range(0, tbl.size() - 1)];
        if (e.op == 6'd0) return {6'd0, 20'($urandom), e.fn};
        return {e.op, 26'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        in_valid = v; in_instr = w; out_ready = ordy; flush = fl;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0);
        #3;
        n_checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_alucontrol !== 8'h00 ||
            out_illegal !== 1'b0 || hilo_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b i=%h a=%h il=%b b=%b, want all zero",
                     out_valid, out_instr, out_alucontrol, out_illegal, hilo_busy);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic_decode();
        do_reset();
        drive(1, I_ADDIU, 1, 0);
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_in_ready: got %b want 1", in_ready);
        end
        tick();
        drive(0, 0, 1, 0);
        #2;
        n_checks++;
        if (out_valid !== 1'b1 || out_alucontrol !== 8'h56 || out_illegal !== 1'b0 ||
            out_instr !== I_ADDIU) begin
            n_fail++;
            $display("FAIL basic_addiu: got v=%b a=%h il=%b i=%h want v=1 a=56 il=0 i=%h",
                     out_valid, out_alucontrol, out_illegal, out_instr, I_ADDIU);
        end
        tick();
        #2;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        drive(1, I_ILL, 1, 0);
        tick();
        drive(0, 0, 1, 0);
        #2;
        n_checks++;
        if (out_valid !== 1'b1 || out_alucontrol !== 8'h00 || out_illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_op: got v=%b a=%h il=%b want v=1 a=00 il=1",
                     out_valid, out_alucontrol, out_illegal);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, I_SUBU, 1, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, I_ADDU, 0, 0);
            #2;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_alucontrol !== 8'h23 ||
                out_instr !== I_SUBU) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b a=%h i=%h want 0 1 23 %h",
                         k, in_ready, out_valid, out_alucontrol, out_instr, I_SUBU);
            end
            tick();
        end
        drive(0, 0, 1, 0);
        #2;
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== I_SUBU) begin
            n_fail++;
            $display("FAIL backpressure_still: got v=%b i=%h want 1 %h", out_valid, out_instr, I_SUBU);
        end
        tick();
        #2;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_div_hazard();
        logic [31:0] p0;
        logic        want_rdy;
        logic        want_busy;
        do_reset();
        p0 = 32'h0;
`ifdef ALUDEC_PERF_CNT_EN
        p0 = perf;
`endif
        drive(1, I_DIV, 1, 0);
        tick();
        for (int i = 0; i <= 37; i++) begin
            drive(1, (i == 10) ? I_ADDU : I_MFLO, 1, 0);
            #2;
            want_rdy  = (i == 10) || (i == 37);
            want_busy = (i >= 1) && (i <= 36);
            n_checks++;
            if (in_ready !== want_rdy || hilo_busy !== want_busy) begin
                n_fail++;
                $display("FAIL div_hazard[%0d]: got rdy=%b busy=%b want %b %b",
                         i, in_ready, hilo_busy, want_rdy, want_busy);
            end
            if (i == 11) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_alucontrol !== 8'h21) begin
                    n_fail++;
                    $display("FAIL div_addu_pass: got v=%b a=%h want 1 21", out_valid, out_alucontrol);
                end
            end
            tick();
        end
        drive(0, 0, 1, 0);
        #2;
        n_checks++;
        if (out_valid !== 1'b1 || out_alucontrol !== 8'h12) begin
            n_fail++;
            $display("FAIL div_mflo_out: got v=%b a=%h want 1 12", out_valid, out_alucontrol);
        end
`ifdef ALUDEC_PERF_CNT_EN
        n_checks++;
        if (perf - p0 !== 32'd36) begin
            n_fail++;
            $display("FAIL perf_stalls: got %0d want 36", perf - p0);
        end
`endif
        tick();
    endtask

    task automatic test_flush_held();
        do_reset();
        drive(1, I_DIV, 1, 0);
        tick();
        drive(0, 0, 0, 1);
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_held_pre: got rdy=%b v=%b want 0 1", in_ready, out_valid);
        end
        tick();
        drive(1, I_MFLO, 1, 0);
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || hilo_busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_held_post: got v=%b busy=%b rdy=%b want 0 0 1",
                     out_valid, hilo_busy, in_ready);
        end
        tick();
        drive(0, 0, 1, 0);
        #2;
        n_checks++;
        if (out_valid !== 1'b1 || out_alucontrol !== 8'h12) begin
            n_fail++;
            $display("FAIL flush_held_mflo: got v=%b a=%h want 1 12", out_valid, out_alucontrol);
        end
        tick();
    endtask

    task automatic test_flush_after_handoff();
        int n_busy;
        do_reset();
        drive(1, I_DIV, 1, 0);
        tick();
        drive(0, 0, 1, 0);
        tick();
        drive(0, 0, 1, 1);
        #2;
        n_busy = hilo_busy ? 1 : 0;
        tick();
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 1, 0);
            #2;
            if (hilo_busy === 1'b1) n_busy++;
            tick();
        end
        n_checks++;
        if (n_busy != 36) begin
            n_fail++;
            $display("FAIL flush_handoff_busy: got %0d busy cycles want 36", n_busy);
        end
    endtask

    task automatic test_reset_mid_divide();
        do_reset();
        drive(1, I_DIV, 1, 0);
        tick();
        drive(1, I_ADDU, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        repeat (16) tick();
        #2;
        n_checks++;
        if (hilo_busy !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got busy=%b v=%b want 1 1", hilo_busy, out_valid);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || hilo_busy !== 1'b0 || out_instr !== 32'h0 ||
            out_alucontrol !== 8'h00 || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got v=%b busy=%b i=%h a=%h il=%b want zeros",
                     out_valid, hilo_busy, out_instr, out_alucontrol, out_illegal);
        end
        tick();
        resetn = 1'b1;
        tick();
        #2;
        n_checks++;
        if (hilo_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_after: got busy=%b want 0", hilo_busy);
        end
    endtask

    task automatic test_random();
        logic        m_valid, m_ill, v, ordy, fl, d_ill, h_ill, haz, rdy;
        logic [31:0] m_instr, w, m_perf;
        logic [7:0]  m_code, d_code, h_code;
        int          m_busy, d_kind, h_kind;
        do_reset();
        m_valid = 0; m_ill = 0; m_instr = 0; m_code = 0; m_busy = 0; m_perf = 0;
        for (int c = 0; c < 1500; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            w    = rand_instr();
            drive(v, w, ordy, fl);
            #2;
            ref_decode(w, d_code, d_ill, d_kind);
            ref_decode(m_instr, h_code, h_ill, h_kind);
            haz = (d_kind != 0) && (m_busy > 0 || (m_valid && h_kind >= 2));
            rdy = (!m_valid || ordy) && !haz && !fl;
            n_checks++;
            if (in_ready !== rdy) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b instr=%h", c, in_ready, rdy, w);
            end
            n_checks++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand_out_valid[%0d]: got %b want %b", c, out_valid, m_valid);
            end
            n_checks++;
            if (out_instr !== m_instr || out_alucontrol !== m_code || out_illegal !== m_ill) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got i=%h a=%h il=%b want %h %h %b",
                         c, out_instr, out_alucontrol, out_illegal, m_instr, m_code, m_ill);
            end
            n_checks++;
            if (hilo_busy !== (m_busy > 0)) begin
                n_fail++;
                $display("FAIL rand_busy[%0d]: got %b want %b", c, hilo_busy, m_busy > 0);
            end
`ifdef ALUDEC_PERF_CNT_EN
            n_checks++;
            if (perf !== m_perf) begin
                n_fail++;
                $display("FAIL rand_perf[%0d]: got %0d want %0d", c, perf, m_perf);
            end
`endif
            if (m_valid && ordy && h_kind >= 2) m_busy = (h_kind == 3) ? 36 : 2;
            else if (m_busy > 0) m_busy--;
            if (v && haz && !fl) m_perf++;
            if (fl) m_valid = 0;
            else if (v && rdy) begin
                m_valid = 1; m_instr = w; m_code = d_code; m_ill = d_ill;
            end else if (m_valid && ordy) m_valid = 0;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_table();
        test_reset();
        test_basic_decode();
        test_illegal();
        test_backpressure();
        test_div_hazard();
        test_flush_held();
        test_flush_after_handoff();
        test_reset_mid_divide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aludec_stage.md
Name: aludec_stage

Overview:
- Registered ALU-control decode stage between ID and EX of the MIPS pipeline.
- Decodes a 32-bit instruction into an ALUOP_W-bit ALU control code and passes it through one pipeline register with a valid/ready handshake and flush.
- Tracks in-flight multi-cycle MULT/MULTU/DIV/DIVU with a busy counter, and holds back later HI/LO-dependent instructions until the result is ready.

Parameters:
- ALUOP_W, 8: width of the ALU control code; the existing EXE_*_OP constants are 8 bit, so ALUOP_W must be ≥ 8 (upper bits zero-filled).
- DIV_LAT, 36: cycles the HI/LO unit is busy after a DIV/DIVU leaves this stage.
- MUL_LAT, 2: cycles the HI/LO unit is busy after a MULT/MULTU leaves this stage.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  32  instruction word.
- flush  in  1  kill the held instruction (branch/exception).
- out_valid  out  1  registered output valid.
- out_ready  in  1  EX stage accepts output.
- out_instr  out  32  registered instruction.
- out_alucontrol  out  ALUOP_W  registered ALU control code.
- out_illegal  out  1  opcode/funct not recognised.
- hilo_busy  out  1  HI/LO unit busy (counter ≠ 0).

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_alucontrol=EXE_NOP_OP, out_illegal=0, busy counter=0, hilo_busy=0.
- Decode covers the same instruction set as the current ALU decoder:
  - Logic: ANDI, XORI, LUI, ORI, AND, OR, XOR, NOR.
  - Shift: SLL, SRL, SRA, SLLV, SRLV, SRAV.
  - Move: MFHI, MFLO, MTHI, MTLO.
  - Arithmetic: ADD, ADDU, SUB, SUBU, SLT, SLTU, ADDI, ADDIU, SLTI, SLTIU, MULT, MULTU, DIV, DIVU.
  - Memory: LB, LBU, LH, LHU, LW, SB, SH, SW.
- Unrecognised op, or op=SPECIAL with an unrecognised funct: alucontrol=EXE_NOP_OP and illegal=1.
- Exception: the all-zero word 0x00000000 decodes as SLL, illegal=0.
- HILO class = MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU.
- hazard = in_instr is HILO class AND (cnt≠0 OR (out_valid AND out_instr is MULT/MULTU/DIV/DIVU)).
- in_ready = (!out_valid OR out_ready) AND !hazard AND !flush.
  - in_ready depends combinationally on in_instr (hazard term).
  - in_ready does not depend on in_valid.
- Accept when in_valid AND in_ready. On accept, at the next edge:
  - out_valid=1;
  - out_instr, out_alucontrol, out_illegal take the decoded values.
- Latency: 1 cycle from accept to out_valid.
- If out_valid AND out_ready AND no accept: out_valid←0 (data fields hold their values).
- If out_valid AND !out_ready: all outputs hold stable.
- flush=1: at the next edge out_valid←0 and no accept.
  - Flush has priority over accept and over the hold rule.
  - Flush does NOT clear cnt: an issued divide keeps running.
- Output handshake of MULT/MULTU (out_valid AND out_ready) loads cnt←MUL_LAT. For DIV/DIVU it loads cnt←DIV_LAT.
- Otherwise, when cnt≠0, cnt decrements by 1 per cycle and saturates at 0.
- cnt width = $clog2(max(DIV_LAT, MUL_LAT)+1).
- hilo_busy = (cnt≠0).
- Non-HILO instructions are never blocked by the counter.
- Back-to-back non-hazard instructions sustain 1 per cycle when out_ready=1.
- Asynchronous reset at any time, including mid-divide, returns every register to its reset value immediately.

Optional Feature:
- Macro ALUDEC_PERF_CNT_EN.
- When defined: adds output port hazard_stall_cnt[31:0].
  - Increments on every cycle with in_valid AND hazard AND !flush.
  - Wraps at 2^32−1 → 0.
  - Reset value 0.
- When undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Shared defines package holds:
  - opcode and funct constants (EXE_* names);
  - ALU op codes (EXE_*_OP, including EXE_NOP_OP);
  - helper functions is_hilo(instr) and is_muldiv(instr).
- One combinational sub-module, aludec_core: instr → {alucontrol, illegal}.
- aludec_stage instantiates aludec_core and adds the register, handshake and counter logic.

Test Plan:
- Basic decode: ADDIU 0x24010005 with in_valid=1, out_ready=1 → next cycle out_valid=1, out_alucontrol=EXE_ADDIU_OP, out_illegal=0.
- Illegal opcode: 0xFC000000 → out_alucontrol=EXE_NOP_OP, out_illegal=1.
- Backpressure: SUBU 0x00851023 accepted, then out_ready=0 for 3 cycles → outputs stable, in_ready=0 for those cycles; out_ready=1 → drains.
- Divide hazard: DIV 0x0085001A hands off, MFLO 0x00001012 presented immediately after → in_ready=0 while hilo_busy=1 (DIV_LAT=36 cycles); MFLO accepted on the first cycle cnt=0. An interleaved ADDU 0x00851021 passes without stall.
- Flush: flush=1 while DIV is held with out_ready=0 → out_valid=0 next cycle, cnt unchanged.
- Flush after hand-off: DIV hands off, flush next cycle → cnt continues counting down from 36.
- Reset and perf counter: assert resetn=0 mid-divide (cnt=20) → cnt=0, out_valid=0 immediately. With ALUDEC_PERF_CNT_EN, the divide hazard scenario gives hazard_stall_cnt=36.
